// File: rtl/rnd_pkg.sv
// Shared rounding-mode encodings and decode helper for the round/saturate pipeline.
package rnd_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC    = 2'b00,
        RND_HALFUP   = 2'b01,
        RND_HALFEVEN = 2'b10,
        RND_RSVD     = 2'b11
    } rnd_mode_t;

    // The reserved encoding behaves as plain truncation.
    function automatic rnd_mode_t rnd_decode(input logic [1:0] raw);
        rnd_mode_t mode;
        case (raw)
            2'b01:   mode = RND_HALFUP;
            2'b10:   mode = RND_HALFEVEN;
            default: mode = RND_TRUNC;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/round_sat_lane.sv
// One lane of the round/saturate datapath: S1 adds the rounding bias, S2 shifts and clips.
// Valid/ready control lives in the top; this lane only sees the two stage load enables.
module round_sat_lane
    import rnd_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int SYM   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en_i,
    input  logic             s2_en_i,
    input  logic [IN_W-1:0]  x_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    localparam int SW = IN_W + 1;
    localparam logic [SW-1:0] HALF_V = (SW'(1) << SHIFT) >> 1;
    // Clip limits expressed at the full internal width so one signed compare covers
    // the case where the shifted value already fits in OUT_W and can never clip.
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = (SYM != 0) ? (~MAX_V + SW'(1)) : ~MAX_V;

    logic [SW-1:0]        bias_s;
    logic signed [SW-1:0] x_ext_s;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] shifted_s;
    logic [OUT_W-1:0]     data_d;
    logic [OUT_W-1:0]     data_q;
    logic                 sat_d;
    logic                 sat_q;

    assign x_ext_s = {x_i[IN_W-1], x_i};

    // Rounding bias selection; half-even folds in the bit that becomes the result LSB.
    always_comb begin
        bias_s = '0;
        case (rnd_decode(mode_i))
            RND_HALFUP: bias_s = HALF_V;
            RND_HALFEVEN: begin
                if (SHIFT == 0) begin
                    bias_s = '0;
                end else begin
                    bias_s = HALF_V - SW'(1) + {{(SW-1){1'b0}}, x_i[SHIFT]};
                end
            end
            default: bias_s = '0;
        endcase
    end

    assign sum_d     = x_ext_s + $signed(bias_s);
    assign shifted_s = sum_q >>> SHIFT;

    // Saturating narrow of the shifted sum.
    always_comb begin
        data_d = shifted_s[OUT_W-1:0];
        sat_d  = 1'b0;
        if (shifted_s > MAX_V) begin
            data_d = MAX_V[OUT_W-1:0];
            sat_d  = 1'b1;
        end else if (shifted_s < MIN_V) begin
            data_d = MIN_V[OUT_W-1:0];
            sat_d  = 1'b1;
        end else begin
            data_d = shifted_s[OUT_W-1:0];
            sat_d  = 1'b0;
        end
    end

    // S1 register: biased sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (s1_en_i) begin
            sum_q <= sum_d;
        end
    end

    // S2 register: clipped result and its clip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sat_q  <= 1'b0;
        end else if (s2_en_i) begin
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage multi-lane round-and-saturate pipeline with valid/ready flow control
// and a sticky overflow flag.
module round_sat_pipe
    import rnd_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int LANES = 2,
    parameter int SYM   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*IN_W-1:0]  s_data,
    input  logic [1:0]             s_mode,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*OUT_W-1:0] m_data,
    output logic [LANES-1:0]       m_sat,
    input  logic                   ovf_clr,
    output logic                   ovf_sticky
);

    logic s1_valid_q;
    logic s1_valid_d;
    logic s2_valid_q;
    logic s2_valid_d;
    logic s2_adv_s;
    logic s1_load_s;
    logic s2_load_s;
    logic out_hs_s;
    logic ovf_q;
    logic ovf_d;

    assign s2_adv_s  = !s2_valid_q || m_ready;
    assign s_ready   = !s1_valid_q || s2_adv_s;
    assign s1_load_s = s_valid && s_ready;
    // S2 only captures real beats so a drained output keeps its last flags.
    assign s2_load_s = s2_adv_s && s1_valid_q;
    assign out_hs_s  = s2_valid_q && m_ready;

    // Stage occupancy and sticky overflow next-state; a set event beats a clear.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        ovf_d      = ovf_q;
        if (s_ready) begin
            s1_valid_d = s_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (out_hs_s && (|m_sat)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign m_valid    = s2_valid_q;
    assign ovf_sticky = ovf_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        round_sat_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT),
            .SYM   (SYM)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s1_en_i (s1_load_s),
            .s2_en_i (s2_load_s),
            .x_i     (s_data[k*IN_W +: IN_W]),
            .mode_i  (s_mode),
            .data_o  (m_data[k*OUT_W +: OUT_W]),
            .sat_o   (m_sat[k])
        );
    end

endmodule

// File: doc/round_sat_pipe.md
ROUND_SAT_PIPE -- requirements
Module: round_sat_pipe

Interface
REQ-001 Parameter IN_W, default 16, input sample width per lane, signed two's complement.
REQ-002 Parameter OUT_W, default 8, output sample width per lane, signed; legal range 2..IN_W+1.
REQ-003 Parameter SHIFT, default 8, LSBs discarded by rounding; legal range 0..IN_W-1.
REQ-004 Parameter LANES, default 2 (I/Q), lanes processed in lockstep.
REQ-005 Parameter SYM, default 0; when 1, negative saturation limit is -(2^(OUT_W-1)-1).
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 s_valid  input  1  input beat valid.
REQ-009 s_ready  output  1  block accepts a beat when s_valid and s_ready are both high.
REQ-010 s_data  input  LANES*IN_W  lane k in bits [k*IN_W +: IN_W].
REQ-011 s_mode  input  2  rounding mode, sampled with each beat: 00 truncate (floor), 01 half-up, 10 half-even, 11 reserved (treated as 00).
REQ-012 m_valid  output  1  output beat valid.
REQ-013 m_ready  input  1  downstream accepts when m_valid and m_ready are both high.
REQ-014 m_data  output  LANES*OUT_W  lane k in bits [k*OUT_W +: OUT_W].
REQ-015 m_sat  output  LANES  per-lane flag: this beat's lane k was clipped.
REQ-016 ovf_clr  input  1  synchronous clear of ovf_sticky.
REQ-017 ovf_sticky  output  1  set when any lane of any accepted output beat has m_sat high.

Function
REQ-018 Two pipeline stages (S1 round-add, S2 shift+saturate); latency exactly 2 cycles from input handshake to m_valid when m_ready is held high.
REQ-019 Stage n advances when it is empty or stage n+1 advances; s_ready = !S1_valid || S2 advances; full throughput of 1 beat/cycle with m_ready high.
REQ-020 While m_valid is high and m_ready is low, m_data, m_sat and m_valid are held stable.
REQ-021 S1 computes in IN_W+1 bits: x + bias. Bias = 0 (truncate), 2^(SHIFT-1) (half-up), 2^(SHIFT-1)-1+x[SHIFT] (half-even); bias = 0 for all modes when SHIFT=0.
REQ-022 S2 arithmetically shifts the S1 sum right by SHIFT, then clips to [MIN, 2^(OUT_W-1)-1], with MIN = -2^(OUT_W-1), or -(2^(OUT_W-1)-1) when SYM=1.
REQ-023 If OUT_W > IN_W+1-SHIFT, the result is sign-extended and never saturates.
REQ-024 m_sat[k] is high exactly when the lane-k result was clipped.
REQ-025 ovf_sticky is set on an output handshake with |m_sat; when ovf_clr and a set event coincide, set wins.
REQ-026 The mode travels with its beat; a mode change between consecutive beats affects only the later beat.

Reset
REQ-027 On rst_n low: S1/S2 valid, m_valid, m_sat and ovf_sticky go to 0 immediately; m_data goes to 0; s_ready is 1 after reset release.
REQ-028 Reset mid-stream drops all in-flight beats; no beat is emitted after reset until a new input handshake.

Structure
REQ-029 Package rnd_pkg holds the mode encodings (RND_TRUNC, RND_HALFUP, RND_HALFEVEN) and a 2-bit mode typedef.
REQ-030 Sub-module round_sat_lane: one lane's S1/S2 datapath registers with a shared stage enable; instantiated LANES times by generate; valid/ready control and ovf_sticky live in the top.

Verification (IN_W=8, OUT_W=4, SHIFT=4, LANES=2, SYM=0 unless noted)
REQ-031 Rounding: inputs 24, 40 and -24 (values 1.5, 2.5, -1.5) -> half-up gives 2, 3, -1; half-even gives 2, 2, -2; truncate gives 1, 2, -2; m_sat=0 throughout.
REQ-032 Saturation: input 127 with half-up -> output 7, m_sat=1, ovf_sticky=1; input -128 with half-up -> output -8, m_sat=0; with SYM=1 -> output -7, m_sat=1.
REQ-033 Backpressure: 10 beats back-to-back with m_ready toggling 1,0,0,1,... -> all 10 beats out in order, none lost or duplicated, outputs stable while stalled, s_ready low when both stages are full.
REQ-034 Latency/throughput: with m_ready=1 -> first m_valid 2 cycles after the first handshake, then 1 beat/cycle.
REQ-035 Reset: assert rst_n low with 2 beats in flight -> m_valid drops asynchronously; no output until new input; ovf_sticky=0.
REQ-036 Sticky clear: ovf_clr in the same cycle as a saturating output handshake -> ovf_sticky remains 1; ovf_clr alone -> 0 the next cycle.
